// File: rtl/residue_check_scheduler.sv
// Round-robin scheduler that time-shares one modulo-419 residue checker among
// NUM_REQ requesters, checks each result against an expected residue and reports it.
module residue_check_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int RES_WIDTH  = 9,
    parameter int TIMEOUT    = 65600,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ*RES_WIDTH-1:0]    req_residue,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            chk_rst_n,
    output logic [DATA_WIDTH-1:0]           chk_data,
    input  logic [15:0]                     chk_out,
    input  logic                            chk_done,
    output logic                            resp_valid,
    output logic [ID_W-1:0]                 resp_id,
    output logic [RES_WIDTH-1:0]            resp_residue,
    output logic                            resp_err,
    output logic                            resp_timeout,
    output logic                            busy,
    output logic [15:0]                     err_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

    state_t                 state, state_nxt;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        lat_id;
    logic [DATA_WIDTH-1:0]  lat_data;
    logic [RES_WIDTH-1:0]   lat_exp;
    logic [RES_WIDTH-1:0]   cap_res;
    logic                   to_flag;
    logic [CNT_W-1:0]       wd_cnt;
    logic                   win_found;
    logic [ID_W-1:0]        win_id;
    logic                   wd_expired;
    logic                   unused_chk_bits;

    assign unused_chk_bits = ^chk_out;
    assign wd_expired      = (wd_cnt == CNT_W'(TIMEOUT - 1));

    // Round-robin search: first requester at or after rr_ptr, wrapping around.
    always_comb begin
        int               idx;
        logic [ID_W-1:0]  cand;
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned; a missing default would infer a latch.
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            cand = ID_W'(idx);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (chk_done || wd_expired) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; the checker is held in reset together with us.
    always_comb begin
        busy         = (state != IDLE);
        chk_rst_n    = !rst && (state != ISSUE);
        chk_data     = lat_data;
        resp_valid   = 1'b0;
        resp_id      = '0;
        resp_residue = '0;
        resp_timeout = 1'b0;
        resp_err     = 1'b0;
        if (state == REPORT) begin
            resp_valid   = 1'b1;
            resp_id      = lat_id;
            resp_residue = cap_res;
            resp_timeout = to_flag;
            resp_err     = to_flag || (cap_res != lat_exp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            rr_ptr    <= '0;
            lat_id    <= '0;
            lat_data  <= '0;
            lat_exp   <= '0;
            cap_res   <= '0;
            to_flag   <= 1'b0;
            wd_cnt    <= '0;
            err_count <= '0;
        end else begin
            grant <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        lat_id   <= win_id;
                        lat_data <= req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
                        lat_exp  <= req_residue[int'(win_id)*RES_WIDTH +: RES_WIDTH];
                        grant    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                    end
                end
                ISSUE: begin
                    wd_cnt  <= '0;
                    to_flag <= 1'b0;
                    cap_res <= '0;
                end
                WAIT: begin
                    if (chk_done) begin
                        cap_res <= chk_out[RES_WIDTH-1:0];
                    end else if (wd_expired) begin
                        to_flag <= 1'b1;
                        cap_res <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    rr_ptr <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
                    if (resp_err && (err_count != 16'hFFFF))
                        err_count <= err_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_residue_check_scheduler.sv
// Self-checking bench: a behavioural counting checker feeds the scheduler, and
// expectations come from plain modulo arithmetic and a simple round-robin model.
module tb_residue_check_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [35:0] req_residue;
    logic [3:0]  grant;
    logic        chk_rst_n;
    logic [15:0] chk_data;
    logic [15:0] chk_out;
    logic        chk_done;
    logic        resp_valid;
    logic [1:0]  resp_id;
    logic [8:0]  resp_residue;
    logic        resp_err;
    logic        resp_timeout;
    logic        busy;
    logic [15:0] err_count;

    // Second instance with a short watchdog and a checker that never finishes.
    logic [3:0]  t_req;
    logic [63:0] t_req_data;
    logic [35:0] t_req_residue;
    logic [3:0]  t_grant;
    logic        t_chk_rst_n;
    logic [15:0] t_chk_data;
    logic        t_resp_valid;
    logic [1:0]  t_resp_id;
    logic [8:0]  t_resp_residue;
    logic        t_resp_err;
    logic        t_resp_timeout;
    logic        t_busy;
    logic [15:0] t_err_count;

    int checks    = 0;
    int errors    = 0;
    int exp_errs  = 0;
    int exp_ptr   = 0;

    residue_check_scheduler dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_residue(req_residue),
        .grant(grant), .chk_rst_n(chk_rst_n), .chk_data(chk_data), .chk_out(chk_out),
        .chk_done(chk_done), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_residue(resp_residue), .resp_err(resp_err), .resp_timeout(resp_timeout),
        .busy(busy), .err_count(err_count)
    );

    residue_check_scheduler #(.TIMEOUT(16)) t_dut (
        .clk(clk), .rst(rst), .req(t_req), .req_data(t_req_data), .req_residue(t_req_residue),
        .grant(t_grant), .chk_rst_n(t_chk_rst_n), .chk_data(t_chk_data), .chk_out(16'h00AB),
        .chk_done(1'b0), .resp_valid(t_resp_valid), .resp_id(t_resp_id),
        .resp_residue(t_resp_residue), .resp_err(t_resp_err), .resp_timeout(t_resp_timeout),
        .busy(t_busy), .err_count(t_err_count)
    );

    // Checker model: one cycle to load the operand, one to start, then one
    // decrement per cycle while counting the residue, then raise done.
    logic [1:0]  m_ph  = 2'd3;
    logic [15:0] m_op  = '0;
    logic [15:0] m_cnt = '0;
    logic [8:0]  m_r   = '0;
    logic [15:0] m_out = '0;
    logic        m_done = 1'b0;
    assign chk_out  = m_out;
    assign chk_done = m_done;

    always @(posedge clk) begin
        if (chk_rst_n === 1'b0) begin
            m_ph   <= 2'd0;
            m_done <= 1'b0;
            m_out  <= '0;
        end else begin
            case (m_ph)
                2'd0: begin m_op <= chk_data; m_ph <= 2'd1; end
                2'd1: begin m_cnt <= m_op; m_r <= '0; m_ph <= 2'd2; end
                2'd2: begin
                    if (m_cnt != 0) begin
                        m_cnt <= m_cnt - 16'd1;
                        m_r   <= (m_r == 9'd418) ? 9'd0 : m_r + 9'd1;
                    end else begin
                        m_done <= 1'b1;
                        m_out  <= {7'd0, m_r};
                        m_ph   <= 2'd3;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic test_reset;
        rst = 1'b1; req = '0; req_data = '0; req_residue = '0;
        t_req = '0; t_req_data = '0; t_req_residue = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (chk_rst_n !== 1'b0) begin errors++; $display("FAIL reset_chk_rst_n: got %b expected 0", chk_rst_n); end
        checks++;
        if ({busy, grant, resp_valid, resp_err, resp_timeout} !== 8'd0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b grant=%b valid=%b err=%b to=%b expected all 0",
                               busy, grant, resp_valid, resp_err, resp_timeout);
        end
        checks++;
        if ({err_count, chk_data, resp_id, resp_residue} !== 43'd0) begin
            errors++; $display("FAIL reset_data: err_count=%0d chk_data=%0d id=%0d res=%0d expected 0",
                               err_count, chk_data, resp_id, resp_residue);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (chk_rst_n !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: chk_rst_n=%b busy=%b expected 1/0", chk_rst_n, busy);
        end
        exp_errs = 0; exp_ptr = 0;
    endtask

    task automatic do_job(input int id, input int data, input int exp_res, input string tag);
        logic [3:0] exp_g;
        int         n;
        bit         got;
        bit         exp_err;
        int         ref_res;
        ref_res = data % 419;
        exp_err = (exp_res != ref_res);
        req_data[id*16 +: 16]  = data[15:0];
        req_residue[id*9 +: 9] = exp_res[8:0];
        req[id] = 1'b1;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1; n++;
            if (grant !== 4'd0) got = 1;
        end
        checks++;
        if (!got || n != 1) begin errors++; $display("FAIL %s grant_latency: got %0d cycles expected 1", tag, n); end
        exp_g = 4'(1 << id);
        checks++;
        if (grant !== exp_g) begin errors++; $display("FAIL %s grant: got %b expected %b", tag, grant, exp_g); end
        checks++;
        if (chk_rst_n !== 1'b0 || chk_data !== data[15:0] || resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s issue: chk_rst_n=%b chk_data=%0d valid=%b expected 0/%0d/0",
                               tag, chk_rst_n, chk_data, resp_valid, data);
        end
        req[id] = 1'b0;
        got = 0; n = 0;
        while (!got && n < data + 100) begin
            @(posedge clk); #1; n++;
            if (resp_valid === 1'b1) got = 1;
        end
        checks++;
        if (!got || n != data + 5) begin errors++; $display("FAIL %s resp_latency: got %0d expected %0d", tag, n, data + 5); end
        checks++;
        if (resp_id !== id[1:0]) begin errors++; $display("FAIL %s resp_id: got %0d expected %0d", tag, resp_id, id); end
        checks++;
        if (resp_residue !== ref_res[8:0]) begin errors++; $display("FAIL %s residue: got %0d expected %0d", tag, resp_residue, ref_res); end
        checks++;
        if (resp_err !== exp_err || resp_timeout !== 1'b0) begin
            errors++; $display("FAIL %s resp_err: got err=%b to=%b expected err=%b to=0", tag, resp_err, resp_timeout, exp_err);
        end
        if (exp_err) exp_errs++;
        exp_ptr = (id + 1) % 4;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s after_report: valid=%b busy=%b expected 0/0", tag, resp_valid, busy);
        end
        checks++;
        if (err_count !== 16'(exp_errs)) begin errors++; $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, exp_errs); end
    endtask

    task automatic test_basic;
        do_job(0, 1000, 162, "basic");
    endtask

    task automatic test_mismatch;
        do_job(0, 1000, 161, "mismatch");
    endtask

    task automatic test_boundaries;
        do_job(1, 0, 0, "op0");
        do_job(2, 419, 0, "op419");
        do_job(0, 418, 418, "op418");
        do_job(1, 5, 424, "exp_ge_419");
        do_job(3, 65535, 171, "op65535");
    endtask

    task automatic test_round_robin;
        int  n;
        bit  got;
        int  exp_id;
        for (int i = 0; i < 4; i++) begin
            req_data[i*16 +: 16]  = 16'(i * 10);
            req_residue[i*9 +: 9] = 9'(i * 10);
        end
        req = 4'hF;
        for (int j = 0; j < 5; j++) begin
            exp_id = exp_ptr;
            got = 0; n = 0;
            while (!got && n < 20) begin
                @(posedge clk); #1; n++;
                if (grant !== 4'd0) got = 1;
            end
            checks++;
            if (!got || grant !== 4'(1 << exp_id)) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", j, grant, 4'(1 << exp_id));
            end
            if (j == 4) req = 4'h0;
            got = 0; n = 0;
            while (!got && n < 200) begin
                @(posedge clk); #1; n++;
                if (resp_valid === 1'b1) got = 1;
            end
            checks++;
            if (!got || resp_id !== exp_id[1:0] || resp_residue !== 9'(exp_id * 10) || resp_err !== 1'b0) begin
                errors++; $display("FAIL rr_resp%0d: got id=%0d res=%0d err=%b expected id=%0d res=%0d err=0",
                                   j, resp_id, resp_residue, resp_err, exp_id, exp_id * 10);
            end
            exp_ptr = (exp_id + 1) % 4;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int id, data, exp_res;
        for (int k = 0; k < 4; k++) begin
            id   = int'($urandom_range(0, 3));
            data = int'($urandom_range(0, 600));
            if ($urandom_range(0, 1) == 0) exp_res = data % 419;
            else                           exp_res = int'($urandom_range(0, 511));
            do_job(id, data, exp_res, "random");
        end
    endtask

    task automatic test_timeout;
        int n;
        bit got;
        t_req_data = {4{16'd100}};
        t_req_residue = {4{9'd100}};
        t_req[1] = 1'b1;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1; n++;
            if (t_grant !== 4'd0) got = 1;
        end
        checks++;
        if (!got || t_grant !== 4'b0010) begin errors++; $display("FAIL to_grant: got %b expected 0010", t_grant); end
        t_req = '0;
        got = 0; n = 0;
        while (!got && n < 100) begin
            @(posedge clk); #1; n++;
            if (t_resp_valid === 1'b1) got = 1;
        end
        checks++;
        if (!got || n != 17) begin errors++; $display("FAIL to_latency: got %0d cycles after grant expected 17", n); end
        checks++;
        if (t_resp_timeout !== 1'b1 || t_resp_err !== 1'b1 || t_resp_residue !== 9'd0 || t_resp_id !== 2'd1) begin
            errors++; $display("FAIL to_resp: got to=%b err=%b res=%0d id=%0d expected 1/1/0/1",
                               t_resp_timeout, t_resp_err, t_resp_residue, t_resp_id);
        end
        @(posedge clk); #1;
        checks++;
        if (t_busy !== 1'b0 || t_resp_valid !== 1'b0 || t_err_count !== 16'd1) begin
            errors++; $display("FAIL to_after: got busy=%b valid=%b err_count=%0d expected 0/0/1",
                               t_busy, t_resp_valid, t_err_count);
        end
    endtask

    task automatic test_reset_mid_job;
        int  n;
        bit  got;
        bit  seen;
        req_data[16 +: 16] = 16'd5000;
        req_residue[9 +: 9] = 9'(5000 % 419);
        req[1] = 1'b1;
        got = 0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1; n++;
            if (grant !== 4'd0) got = 1;
        end
        req[1] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (!got || busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b expected 1", busy); end
        rst = 1'b1;
        #1;
        checks++;
        if (chk_rst_n !== 1'b0) begin errors++; $display("FAIL midrst_chk_rst_n: got %b expected 0", chk_rst_n); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || err_count !== 16'd0 || chk_data !== 16'd0) begin
            errors++; $display("FAIL midrst_state: busy=%b valid=%b err_count=%0d chk_data=%0d expected 0",
                               busy, resp_valid, err_count, chk_data);
        end
        rst = 1'b0;
        exp_errs = 0; exp_ptr = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0 || grant !== 4'd0) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL midrst_quiet: got a response or grant after reset, expected none"); end
        do_job(2, 838, 0, "after_midrst");
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_basic();
        test_mismatch();
        test_boundaries();
        test_round_robin();
        test_random();
        test_timeout();
        test_reset_mid_job();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
